// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode map, FSM state encoding and flag bit positions for alu_seq
// Rev 1.0
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_DIVU = 4'b0110;
  localparam logic [3:0] OP_REMU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_ROL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int FLG_S = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// alu_muldiv_iter : WIDTH-cycle radix-2 shift-add multiplier / restoring divider
// Rev 1.0
// ============================================================================
module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             b_zero_o
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic             busy_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_diff;

  // hi:lo is the product accumulator for MUL and remainder:quotient for DIV
  assign w_mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign w_div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, opb_q};

  always_comb begin
    hi_d = w_mul_sum[WIDTH:1];
    lo_d = {w_mul_sum[0], lo_q[WIDTH-1:1]};
    if (div_q) begin
      if (w_div_diff[WIDTH]) begin
        hi_d = w_div_sh[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_d = w_div_diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opb_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      div_q  <= div_i;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= a_i;
      opb_q  <= b_i;
    end else if (busy_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CW'(1);
      if (last_o) busy_q <= 1'b0;
    end
  end

  assign last_o   = busy_q && (cnt_q == LAST_CNT);
  assign hi_o     = hi_d;
  assign lo_o     = lo_d;
  assign b_zero_o = (opb_q == '0);

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : registered valid/ready ALU with iterative MUL/DIVU/REMU
// Rev 1.0
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             N_RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DATA_A,
  input  logic [WIDTH-1:0] DATA_B,
  input  logic [3:0]       S_ALU,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [3:0]       FLAG_OUT
);

  localparam logic [SHW:0] W_AMT = (SHW + 1)'(WIDTH);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             rem_q;
  logic [WIDTH-1:0] alu_out_q;
  logic [WIDTH-1:0] alu_out_d;
  logic [3:0]       flag_q;
  logic [3:0]       flag_d;

  logic             w_accept;
  logic             w_iter_op;
  logic             w_start;
  logic             w_eng_last;
  logic [WIDTH-1:0] w_eng_hi;
  logic [WIDTH-1:0] w_eng_lo;
  logic             w_eng_bz;

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_add_ext;
  logic [WIDTH:0]   w_sub_ext;
  logic [WIDTH:0]   w_sll_ext;
  logic [WIDTH:0]   w_srl_ext;
  logic [WIDTH:0]   w_sra_ext;
  logic [WIDTH-1:0] w_rol_res;
  logic [WIDTH-1:0] w_sc_res;
  logic             w_sc_c;
  logic             w_sc_v;
  logic             w_load;
  logic [WIDTH-1:0] w_res_sel;
  logic             w_c_sel;
  logic             w_v_sel;
  logic [3:0]       w_flag_new;

  assign w_accept  = IN_VALID && (state_q == ST_IDLE);
  assign w_iter_op = is_iter_op(S_ALU);
  assign w_start   = w_accept && w_iter_op;

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk_i    (CLK),
    .rst_ni   (N_RST),
    .start_i  (w_start),
    .div_i    (S_ALU != OP_MUL),
    .a_i      (DATA_A),
    .b_i      (DATA_B),
    .last_o   (w_eng_last),
    .hi_o     (w_eng_hi),
    .lo_o     (w_eng_lo),
    .b_zero_o (w_eng_bz)
  );

  // Extended shifts keep the last bit shifted out in the extra position
  assign w_shamt   = DATA_B[SHW-1:0];
  assign w_add_ext = {1'b0, DATA_A} + {1'b0, DATA_B};
  assign w_sub_ext = {1'b0, DATA_A} - {1'b0, DATA_B};
  assign w_sll_ext = {1'b0, DATA_A} << w_shamt;
  assign w_srl_ext = {DATA_A, 1'b0} >> w_shamt;
  assign w_sra_ext = $signed({DATA_A, 1'b0}) >>> w_shamt;
  assign w_rol_res = (DATA_A << w_shamt) | (DATA_A >> (W_AMT - {1'b0, w_shamt}));

  always_comb begin
    w_sc_res = '0;
    w_sc_c   = 1'b0;
    w_sc_v   = 1'b0;
    case (S_ALU)
      OP_ADD: begin
        w_sc_res = w_add_ext[WIDTH-1:0];
        w_sc_c   = w_add_ext[WIDTH];
        w_sc_v   = (DATA_A[WIDTH-1] == DATA_B[WIDTH-1]) &&
                   (w_add_ext[WIDTH-1] != DATA_A[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_res = w_sub_ext[WIDTH-1:0];
        w_sc_c   = w_sub_ext[WIDTH];
        w_sc_v   = (DATA_A[WIDTH-1] != DATA_B[WIDTH-1]) &&
                   (w_sub_ext[WIDTH-1] != DATA_A[WIDTH-1]);
      end
      OP_AND: w_sc_res = DATA_A & DATA_B;
      OP_OR:  w_sc_res = DATA_A | DATA_B;
      OP_XOR: w_sc_res = DATA_A ^ DATA_B;
      OP_SLL: begin
        w_sc_res = w_sll_ext[WIDTH-1:0];
        w_sc_c   = w_sll_ext[WIDTH];
      end
      OP_ROL: begin
        w_sc_res = w_rol_res;
        w_sc_c   = w_sll_ext[WIDTH];
      end
      OP_SRL: begin
        w_sc_res = w_srl_ext[WIDTH:1];
        w_sc_c   = w_srl_ext[0];
      end
      OP_SRA: begin
        w_sc_res = w_sra_ext[WIDTH:1];
        w_sc_c   = w_sra_ext[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_load    = 1'b0;
    w_res_sel = w_sc_res;
    w_c_sel   = w_sc_c;
    w_v_sel   = w_sc_v;
    case (state_q)
      ST_IDLE: w_load = w_accept && !w_iter_op;
      ST_MUL: begin
        w_load    = w_eng_last;
        w_res_sel = w_eng_lo;
        w_c_sel   = |w_eng_hi;
        w_v_sel   = 1'b0;
      end
      ST_DIV: begin
        w_load    = w_eng_last;
        w_res_sel = rem_q ? w_eng_hi : w_eng_lo;
        w_c_sel   = 1'b0;
        w_v_sel   = w_eng_bz;
      end
      default: ;
    endcase
    w_flag_new        = '0;
    w_flag_new[FLG_S] = w_res_sel[WIDTH-1];
    w_flag_new[FLG_Z] = (w_res_sel == '0);
    w_flag_new[FLG_C] = w_c_sel;
    w_flag_new[FLG_V] = w_v_sel;
    alu_out_d = w_load ? w_res_sel  : alu_out_q;
    flag_d    = w_load ? w_flag_new : flag_q;
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (S_ALU == OP_MUL) state_d = ST_MUL;
          else if (w_iter_op)  state_d = ST_DIV;
          else                 state_d = ST_DONE;
        end
      end
      ST_MUL:  if (w_eng_last) state_d = ST_DONE;
      ST_DIV:  if (w_eng_last) state_d = ST_DONE;
      ST_DONE: if (OUT_READY)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = (state_q == ST_IDLE);
    OUT_VALID = (state_q == ST_DONE);
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      alu_out_q <= '0;
      flag_q    <= '0;
      rem_q     <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      flag_q    <= flag_d;
      if (w_start) rem_q <= (S_ALU == OP_REMU);
    end
  end

  assign ALU_OUT  = alu_out_q;
  assign FLAG_OUT = flag_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_seq : scoreboard bench for alu_seq at WIDTH=16
// Rev 1.0
// ============================================================================
module tb_alu_seq;

  localparam logic [3:0] T_ADD = 4'b0000, T_SUB = 4'b0001, T_AND = 4'b0010;
  localparam logic [3:0] T_OR  = 4'b0011, T_XOR = 4'b0100, T_MUL = 4'b0101;
  localparam logic [3:0] T_DIVU = 4'b0110, T_REMU = 4'b0111, T_SLL = 4'b1000;
  localparam logic [3:0] T_ROL = 4'b1001, T_SRL = 4'b1010, T_SRA = 4'b1011;

  logic        CLK = 1'b0;
  logic        N_RST = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        OUT_READY = 1'b1;
  logic [15:0] DATA_A = '0;
  logic [15:0] DATA_B = '0;
  logic [3:0]  S_ALU = '0;
  logic        IN_READY;
  logic        OUT_VALID;
  logic [15:0] ALU_OUT;
  logic [3:0]  FLAG_OUT;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [3:0]  s_op  [14] = '{T_ADD, T_SUB, T_SRA, T_AND, T_OR, T_XOR, T_SLL,
                              T_ROL, T_SRL, T_SLL, T_ADD, T_SUB, 4'b1100, T_SRA};
  logic [15:0] s_a   [14] = '{16'h7FFF, 16'h0000, 16'h8001, 16'hF0F0, 16'h0000, 16'hAAAA, 16'h8001,
                              16'h9001, 16'h8003, 16'h1234, 16'hFFFF, 16'h8000, 16'h1234, 16'h8000};
  logic [15:0] s_b   [14] = '{16'h0001, 16'h0001, 16'h0001, 16'hFF00, 16'h0000, 16'h5555, 16'h0001,
                              16'h0004, 16'h0002, 16'hFFF0, 16'h0001, 16'h0001, 16'h5678, 16'h000F};
  logic [15:0] s_res [14] = '{16'h8000, 16'hFFFF, 16'hC000, 16'hF000, 16'h0000, 16'hFFFF, 16'h0002,
                              16'h0019, 16'h2000, 16'h1234, 16'h0000, 16'h7FFF, 16'h0000, 16'hFFFF};
  logic [3:0]  s_flg [14] = '{4'b1001, 4'b1010, 4'b1010, 4'b1000, 4'b0100, 4'b1000, 4'b0010,
                              4'b0010, 4'b0010, 4'b0000, 4'b0110, 4'b0001, 4'b0100, 4'b1000};

  logic [3:0]  d_op  [5] = '{T_DIVU, T_REMU, T_DIVU, T_REMU, T_DIVU};
  logic [15:0] d_a   [5] = '{16'd100, 16'd100, 16'd5, 16'd5, 16'hFFFF};
  logic [15:0] d_b   [5] = '{16'd7, 16'd7, 16'd0, 16'd0, 16'd1};
  logic [15:0] d_res [5] = '{16'h000E, 16'h0002, 16'hFFFF, 16'h0005, 16'hFFFF};
  logic [3:0]  d_flg [5] = '{4'b0000, 4'b0000, 4'b1001, 4'b0001, 4'b1000};

  alu_seq #(.WIDTH(16)) dut (
    .CLK       (CLK),
    .N_RST     (N_RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .DATA_A    (DATA_A),
    .DATA_B    (DATA_B),
    .S_ALU     (S_ALU),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .ALU_OUT   (ALU_OUT),
    .FLAG_OUT  (FLAG_OUT)
  );

  always #5 CLK = ~CLK;

  // Reference: returns {S,Z,C,V, result}
  function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    logic [31:0] p;
    logic [15:0] r;
    logic        c;
    logic        v;
    int          n;
    r = '0; c = 1'b0; v = 1'b0; n = int'(b[3:0]);
    case (op)
      T_ADD: begin t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16];
                   v = (a[15] == b[15]) && (r[15] != a[15]); end
      T_SUB: begin t = {1'b0, a} - {1'b0, b}; r = t[15:0]; c = t[16];
                   v = (a[15] != b[15]) && (r[15] != a[15]); end
      T_AND: r = a & b;
      T_OR:  r = a | b;
      T_XOR: r = a ^ b;
      T_MUL: begin p = {16'd0, a} * {16'd0, b}; r = p[15:0]; c = |p[31:16]; end
      T_DIVU: if (b == 16'd0) begin r = 16'hFFFF; v = 1'b1; end else r = a / b;
      T_REMU: if (b == 16'd0) begin r = a; v = 1'b1; end else r = a % b;
      T_SLL: begin r = a << n; c = (n != 0) ? a[16-n] : 1'b0; end
      T_ROL: begin r = (n == 0) ? a : ((a << n) | (a >> (16 - n))); c = (n != 0) ? a[16-n] : 1'b0; end
      T_SRL: begin r = a >> n; c = (n != 0) ? a[n-1] : 1'b0; end
      T_SRA: begin r = $signed(a) >>> n; c = (n != 0) ? a[n-1] : 1'b0; end
      default: ;
    endcase
    return {r[15], (r == 16'd0), c, v, r};
  endfunction

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (IN_READY === 1'b1) break;
      @(negedge CLK);
    end
    if (IN_READY === 1'b1) begin
      S_ALU = op; DATA_A = a; DATA_B = b; IN_VALID = 1'b1;
      @(negedge CLK);
      IN_VALID = 1'b0;
      S_ALU = 4'($urandom); DATA_A = 16'($urandom); DATA_B = 16'($urandom);
      ok = 1'b1;
    end
  endtask

  task automatic wait_out(output bit ok, output int lat);
    lat = 1;
    while (OUT_VALID !== 1'b1 && lat < 80) begin
      @(negedge CLK);
      lat++;
    end
    ok = (OUT_VALID === 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
    n_cmp++; if (ALU_OUT !== 16'h0) begin n_err++; $display("FAIL reset_alu_out: got %h want 0000", ALU_OUT); end
    n_cmp++; if (FLAG_OUT !== 4'h0) begin n_err++; $display("FAIL reset_flag_out: got %b want 0000", FLAG_OUT); end
    N_RST = 1'b1;
    @(negedge CLK);
    n_cmp++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: in_ready=%b out_valid=%b want 1/0", IN_READY, OUT_VALID);
    end
  endtask

  task automatic test_single();
    bit ok; int lat; exp_t e;
    for (int i = 0; i < 14; i++) begin
      sb.push_back(exp_t'{s_res[i], s_flg[i], 1});
      send(s_op[i], s_a[i], s_b[i], ok);
      if (ok) wait_out(ok, lat);
      e = sb.pop_front();
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL single[%0d]_timeout: out_valid=%b want 1", i, OUT_VALID); end
      else begin
        n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL single[%0d]_latency: got %0d want %0d", i, lat, e.lat); end
        n_cmp++; if (ALU_OUT !== e.res) begin n_err++; $display("FAIL single[%0d]_result: got %h want %h", i, ALU_OUT, e.res); end
        n_cmp++; if (FLAG_OUT !== e.flg) begin n_err++; $display("FAIL single[%0d]_flags: got %b want %b", i, FLAG_OUT, e.flg); end
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_mul();
    bit ok; int lat; int rdy_bad; exp_t e;
    sb.push_back(exp_t'{16'h5F90, 4'b0010, 17});
    send(T_MUL, 16'd300, 16'd300, ok);
    lat = 1; rdy_bad = 0;
    while (ok && OUT_VALID !== 1'b1 && lat < 80) begin
      if (IN_READY !== 1'b0) rdy_bad++;
      @(negedge CLK);
      lat++;
    end
    if (IN_READY !== 1'b0) rdy_bad++;
    ok = ok && (OUT_VALID === 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL mul_timeout: out_valid=%b want 1", OUT_VALID); end
    else begin
      n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL mul_latency: got %0d want %0d", lat, e.lat); end
      n_cmp++; if (ALU_OUT !== e.res) begin n_err++; $display("FAIL mul_result: got %h want %h", ALU_OUT, e.res); end
      n_cmp++; if (FLAG_OUT !== e.flg) begin n_err++; $display("FAIL mul_flags: got %b want %b", FLAG_OUT, e.flg); end
      n_cmp++; if (rdy_bad != 0) begin n_err++; $display("FAIL mul_in_ready_busy: got %0d high cycles want 0", rdy_bad); end
    end
    @(negedge CLK);
  endtask

  task automatic test_div();
    bit ok; int lat; exp_t e;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(exp_t'{d_res[i], d_flg[i], 17});
      send(d_op[i], d_a[i], d_b[i], ok);
      if (ok) wait_out(ok, lat);
      e = sb.pop_front();
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL div[%0d]_timeout: out_valid=%b want 1", i, OUT_VALID); end
      else begin
        n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL div[%0d]_latency: got %0d want %0d", i, lat, e.lat); end
        n_cmp++; if (ALU_OUT !== e.res) begin n_err++; $display("FAIL div[%0d]_result: got %h want %h", i, ALU_OUT, e.res); end
        n_cmp++; if (FLAG_OUT !== e.flg) begin n_err++; $display("FAIL div[%0d]_flags: got %b want %b", i, FLAG_OUT, e.flg); end
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat; int bad; int extra; exp_t e;
    OUT_READY = 1'b0;
    sb.push_back(exp_t'{16'h0000, 4'b0111, 1});
    send(T_ADD, 16'h8000, 16'h8000, ok);
    if (ok) wait_out(ok, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL bp_timeout: out_valid=%b want 1", OUT_VALID); end
    else begin
      n_cmp++; if (ALU_OUT !== e.res || FLAG_OUT !== e.flg) begin
        n_err++; $display("FAIL bp_result: got %h/%b want %h/%b", ALU_OUT, FLAG_OUT, e.res, e.flg);
      end
      S_ALU = T_MUL; DATA_A = 16'd3; DATA_B = 16'd3; IN_VALID = 1'b1;
      bad = 0;
      repeat (5) begin
        @(negedge CLK);
        if (OUT_VALID !== 1'b1 || ALU_OUT !== e.res || FLAG_OUT !== e.flg || IN_READY !== 1'b0) bad++;
      end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL bp_stall_stable: got %0d bad cycles want 0", bad); end
      IN_VALID = 1'b0; OUT_READY = 1'b1;
      @(negedge CLK);
      n_cmp++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
        n_err++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", OUT_VALID, IN_READY);
      end
      extra = 0;
      repeat (20) begin
        @(negedge CLK);
        if (OUT_VALID !== 1'b0) extra++;
      end
      n_cmp++; if (extra != 0) begin n_err++; $display("FAIL bp_stray_accept: got %0d valid cycles want 0", extra); end
    end
    OUT_READY = 1'b1;
  endtask

  task automatic test_reset_mid_mul();
    bit ok; int lat; int seen;
    send(T_ADD, 16'd1, 16'd1, ok);
    if (ok) wait_out(ok, lat);
    n_cmp++; if (!ok || ALU_OUT !== 16'h0002) begin n_err++; $display("FAIL abort_pre_add: got %h want 0002", ALU_OUT); end
    @(negedge CLK);
    send(T_MUL, 16'd300, 16'd300, ok);
    repeat (7) @(negedge CLK);
    N_RST = 1'b0;
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL abort_in_ready: got %b want 1", IN_READY); end
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL abort_out_valid: got %b want 0", OUT_VALID); end
    n_cmp++; if (ALU_OUT !== 16'h0 || FLAG_OUT !== 4'h0) begin
      n_err++; $display("FAIL abort_outputs: got %h/%b want 0000/0000", ALU_OUT, FLAG_OUT);
    end
    repeat (2) @(negedge CLK);
    N_RST = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge CLK);
      if (OUT_VALID !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); end
    sb.push_back(exp_t'{16'h0005, 4'b0000, 1});
    send(T_ADD, 16'd2, 16'd3, ok);
    if (ok) wait_out(ok, lat);
    begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (!ok || lat != e.lat || ALU_OUT !== e.res || FLAG_OUT !== e.flg) begin
        n_err++; $display("FAIL abort_next_add: got %h/%b lat %0d want %h/%b lat %0d",
                          ALU_OUT, FLAG_OUT, lat, e.res, e.flg, e.lat);
      end
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    bit ok; int lat; exp_t e; logic [19:0] m;
    logic [3:0] op; logic [15:0] a; logic [15:0] b;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = (i % 5 == 0) ? 16'd0 : 16'($urandom);
      m  = model(op, a, b);
      sb.push_back(exp_t'{m[15:0], m[19:16], (op == T_MUL || op == T_DIVU || op == T_REMU) ? 17 : 1});
      send(op, a, b, ok);
      if (ok) wait_out(ok, lat);
      e = sb.pop_front();
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL b2b[%0d]_timeout: out_valid=%b want 1", i, OUT_VALID); end
      else begin
        n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL b2b[%0d]_latency op=%b: got %0d want %0d", i, op, lat, e.lat); end
        n_cmp++; if (ALU_OUT !== e.res) begin
          n_err++; $display("FAIL b2b[%0d]_result op=%b a=%h b=%h: got %h want %h", i, op, a, b, ALU_OUT, e.res);
        end
        n_cmp++; if (FLAG_OUT !== e.flg) begin
          n_err++; $display("FAIL b2b[%0d]_flags op=%b a=%h b=%h: got %b want %b", i, op, a, b, FLAG_OUT, e.flg);
        end
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
